// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key map and row drive helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;

  // Indexed by {row, column}; * = 14, # = 15, A..D = 10..13
  localparam logic [3:0] KEY_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-numbered low column wins when several are pressed.
  function automatic logic [1:0] first_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!cols[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the scanner to the detonator digit input.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output key_code, output key_valid, output key_down);
  modport slave  (input  key_code, input  key_valid, input  key_down);
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = $clog2(SCAN_DIV);

  logic [W-1:0] count;

  assign tick = (count == W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (tick) count <= '0;
    else           count <= count + W'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low key matrix, debounces one key at a time and emits
// a registered key code with a single-cycle valid strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEB_CNT  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  keypad_scanner_if.master key
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CNT - 1);

  logic       tick;
  logic [3:0] sync1, sync2;
  state_t     state, state_n;
  logic [1:0] r, r_n, c, c_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] code, code_n, row_q, row_n;
  logic       valid, valid_n, down, down_n;
  logic       any_low;
  logic [1:0] win;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign any_low = (sync2 != 4'hF);
  assign win     = first_low(sync2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      state <= SCAN;
      r     <= '0;
      c     <= '0;
      cnt   <= '0;
      code  <= '0;
      valid <= 1'b0;
      down  <= 1'b0;
      row_q <= ROW_IDLE;
    end else begin
      sync1 <= col;
      sync2 <= sync1;
      state <= state_n;
      r     <= r_n;
      c     <= c_n;
      cnt   <= cnt_n;
      code  <= code_n;
      valid <= valid_n;
      down  <= down_n;
      row_q <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    cnt_n   = cnt;
    code_n  = code;
    valid_n = 1'b0;
    down_n  = down;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (any_low) begin
            c_n     = win;
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            r_n = r + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low && win == c) begin
            if (cnt == DEB_LAST) begin
              code_n  = KEY_MAP[{r, c}];
              valid_n = 1'b1;
              down_n  = 1'b1;
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            cnt_n   = '0;
            state_n = SCAN;
          end
        end
        HOLD: begin
          // Comparing against DEB_LAST before incrementing means the
          // DEB_CNT-th consecutive released tick is the one that exits.
          if (!any_low) begin
            if (cnt == DEB_LAST) begin
              cnt_n   = '0;
              r_n     = r + 2'd1;
              down_n  = 1'b0;
              state_n = SCAN;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
    row_n = row_drive(r_n);
  end

  assign row           = row_q;
  assign key.key_code  = code;
  assign key.key_valid = valid;
  assign key.key_down  = down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: physical keypad matrix model drives col from row,
// a behavioural scanner model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic [15:0] pressed = '0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEB_CNT(DC)) dut (
    .clk (clk),
    .rst (rst),
    .col (col),
    .row (row),
    .key (kif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dut_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad legend laid out row by row, column 0 first.
  string KEYS = "123A456B789C*0#D";

  function automatic int code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch - "0");
    if (ch >= "A" && ch <= "D") return 10 + int'(ch - "A");
    if (ch == "*") return 14;
    return 15;
  endfunction

  function automatic int idx_of(input byte ch);
    for (int i = 0; i < 16; i++) if (KEYS[i] == ch) return i;
    return 0;
  endfunction

  // Physical matrix: a pressed key pulls its column low when its row is driven.
  always @(negedge clk) begin
    logic [3:0] cv;
    cv = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!row[i])
        for (int j = 0; j < 4; j++)
          if (pressed[i*4+j]) cv[j] = 1'b0;
    col = cv;
  end

  // Behavioural model
  int   m_cycle, m_phase, m_r, m_col, m_streak, m_code;
  bit   m_valid, m_down;
  logic [3:0] m_s1, m_s2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cycle = 0; m_phase = 0; m_r = 0; m_col = 0; m_streak = 0;
      m_code = 0; m_valid = 0; m_down = 0; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      logic [3:0] seen;
      bit is_tick;
      int low;
      seen    = m_s2;
      m_s2    = m_s1;
      m_s1    = col;
      is_tick = (m_cycle % SD) == SD - 1;
      m_cycle++;
      m_valid = 0;
      low = -1;
      for (int j = 3; j >= 0; j--) if (!seen[j]) low = j;
      if (is_tick) begin
        if (m_phase == 0) begin
          if (low >= 0) begin m_col = low; m_streak = 0; m_phase = 1; end
          else m_r = (m_r + 1) % 4;
        end else if (m_phase == 1) begin
          if (low == m_col) begin
            m_streak++;
            if (m_streak == DC) begin
              m_code = code_of(KEYS[m_r*4 + m_col]);
              m_valid = 1; m_down = 1; m_streak = 0; m_phase = 2;
            end
          end else begin
            m_streak = 0; m_phase = 0;
          end
        end else begin
          if (low < 0) begin
            m_streak++;
            if (m_streak == DC) begin
              m_streak = 0; m_r = (m_r + 1) % 4; m_down = 0; m_phase = 0;
            end
          end else m_streak = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("row",       row,           32'(~(4'b0001 << m_r) & 4'hF));
    check("key_code",  kif.key_code,  32'(m_code));
    check("key_valid", kif.key_valid, 32'(m_valid));
    check("key_down",  kif.key_down,  32'(m_down));
    if (kif.key_valid === 1'b1) dut_pulses++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_down(input logic lvl, input string name);
    int t;
    t = 0;
    while (kif.key_down !== lvl && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check({name, "_timeout"}, 32'(kif.key_down), 32'(lvl));
  endtask

  initial begin
    int base;
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1110; exp_rows[1] = 4'b1101;
    exp_rows[2] = 4'b1011; exp_rows[3] = 4'b0111;

    idle(3);
    check("reset_row",   row,           32'h0000000E);
    check("reset_code",  kif.key_code,  32'h0);
    check("reset_valid", kif.key_valid, 32'h0);
    check("reset_down",  kif.key_down,  32'h0);
    rst = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      check("scan_row", row, 32'(exp_rows[k/4]));
    end
    check("scan_no_pulse", dut_pulses, 32'd0);

    // Single press of 5, then release
    base = dut_pulses;
    pressed[idx_of("5")] = 1'b1;
    idle(40);
    check("press5_code", kif.key_code, 32'd5);
    check("press5_down", kif.key_down, 32'd1);
    pressed = '0;
    wait_down(1'b0, "release5");
    check("press5_resume_row", row, 32'h0000000B);
    check("press5_pulses", dut_pulses - base, 32'd1);
    idle(10);

    // Bounce: one tick of col0 on row 3
    base = dut_pulses;
    while (row !== 4'b0111) @(negedge clk);
    pressed[idx_of("*")] = 1'b1;
    idle(SD);
    pressed = '0;
    idle(30);
    check("bounce_pulses", dut_pulses - base, 32'd0);
    check("bounce_down", kif.key_down, 32'd0);

    // Two columns low on row 2
    base = dut_pulses;
    pressed[idx_of("7")] = 1'b1;
    pressed[idx_of("9")] = 1'b1;
    idle(40);
    pressed = '0;
    idle(40);
    check("multi_code", kif.key_code, 32'd7);
    check("multi_pulses", dut_pulses - base, 32'd1);

    // 0 then #
    base = dut_pulses;
    pressed[idx_of("0")] = 1'b1;
    idle(40);
    check("digit0_code", kif.key_code, 32'd0);
    pressed = '0;
    idle(40);
    pressed[idx_of("#")] = 1'b1;
    idle(40);
    pressed = '0;
    idle(40);
    check("hash_code", kif.key_code, 32'd15);
    check("zero_hash_pulses", dut_pulses - base, 32'd2);

    // Reset during HOLD with the key still held
    pressed[idx_of("5")] = 1'b1;
    wait_down(1'b1, "hold5");
    idle(3);
    #1 rst = 1'b0;
    #1;
    check("rst_hold_down", kif.key_down, 32'd0);
    check("rst_hold_row",  row,          32'h0000000E);
    check("rst_hold_code", kif.key_code, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    base = dut_pulses;
    idle(60);
    check("rst_hold_repulse", dut_pulses - base, 32'd1);
    check("rst_hold_code5", kif.key_code, 32'd5);
    pressed = '0;
    idle(40);

    // Randomised presses, bounces and multi-key presses
    for (int n = 0; n < 40; n++) begin
      logic [15:0] m;
      m = '0;
      m[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 15)] = 1'b1;
      pressed = m;
      idle($urandom_range(2, 48));
      pressed = '0;
      idle($urandom_range(2, 48));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
